// File: rtl/gpio_input_filter.sv
// 16-pin GPIO input synchronizer and per-pin debounce filter with a small register block at 0x4000.
// Optional prescaled debounce tick when GPIO_FILTER_PRESCALER_EN is defined; otherwise tick fires every cycle.
module gpio_input_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] gpio_pins_in,
  output logic [15:0] gpio_pin_state,
  input  logic [15:0] data_bus_write,
  output logic [15:0] data_bus_read,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  input  logic        data_bus_select
);

  localparam logic [31:0] ADDR_STATE  = 32'h0000_4000;
  localparam logic [31:0] ADDR_RAW    = 32'h0000_4004;
  localparam logic [31:0] ADDR_ENABLE = 32'h0000_4008;
  localparam logic [31:0] ADDR_CONFIG = 32'h0000_400C;

  logic [15:0] sync_reg [SYNC_STAGES];
  logic [15:0] sync_raw;
  logic [15:0] pin_state_reg;
  logic [15:0] pin_state_next;
  logic [15:0] filter_enable_reg;
  logic [3:0]  threshold_reg;
  logic [3:0]  cnt_reg  [16];
  logic [3:0]  cnt_next [16];
  logic [7:0]  prescaler_rd;
  logic        tick;
  logic        bus_wr;
  logic        enable_wr;
  logic        config_wr;

  assign bus_wr    = (data_bus_mode == 2'b10) && data_bus_select;
  assign enable_wr = bus_wr && (data_bus_addr == ADDR_ENABLE);
  assign config_wr = bus_wr && (data_bus_addr == ADDR_CONFIG);
  assign sync_raw  = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= gpio_pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

`ifdef GPIO_FILTER_PRESCALER_EN
  logic [7:0] prescaler_reg;
  logic [7:0] presc_cnt_reg;

  assign tick         = (presc_cnt_reg == prescaler_reg);
  assign prescaler_rd = prescaler_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_reg <= '0;
      presc_cnt_reg <= '0;
    end else if (config_wr) begin
      prescaler_reg <= data_bus_write[15:8];
      presc_cnt_reg <= '0;
    end else if (tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 8'd1;
    end
  end
`else
  assign tick         = 1'b1;
  assign prescaler_rd = 8'h00;
`endif

  // A config write freezes acceptance for one cycle so every pin restarts its count from zero.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pin
    logic differs;
    logic accept;
    assign differs = sync_raw[gi] != pin_state_reg[gi];
    assign accept  = differs && tick && !config_wr && (cnt_reg[gi] == threshold_reg);

    assign pin_state_next[gi] = !filter_enable_reg[gi] ? sync_raw[gi] :
                                accept                 ? sync_raw[gi] : pin_state_reg[gi];

    assign cnt_next[gi] = (!filter_enable_reg[gi] || config_wr || !differs || accept) ? 4'd0 :
                          tick ? cnt_reg[gi] + 4'd1 : cnt_reg[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_state_reg     <= '0;
      filter_enable_reg <= '0;
      threshold_reg     <= '0;
      for (int p = 0; p < 16; p++) cnt_reg[p] <= '0;
    end else begin
      pin_state_reg <= pin_state_next;
      for (int p = 0; p < 16; p++) cnt_reg[p] <= cnt_next[p];
      if (enable_wr) filter_enable_reg <= data_bus_write;
      if (config_wr) threshold_reg <= data_bus_write[3:0];
    end
  end

  always_comb begin
    data_bus_read = 16'h0000;
    case (data_bus_addr)
      ADDR_STATE:  data_bus_read = pin_state_reg;
      ADDR_RAW:    data_bus_read = sync_raw;
      ADDR_ENABLE: data_bus_read = filter_enable_reg;
      ADDR_CONFIG: data_bus_read = {prescaler_rd, 4'h0, threshold_reg};
      default:     data_bus_read = 16'h0000;
    endcase
  end

  assign gpio_pin_state = pin_state_reg;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter: directed scenarios plus randomized traffic against a tick-counting model.
module tb_gpio_input_filter;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gpio_pins_in = '0;
  logic [15:0] gpio_pin_state;
  logic [15:0] data_bus_write = '0;
  logic [15:0] data_bus_read;
  logic [31:0] data_bus_addr = 32'h4000;
  logic [1:0]  data_bus_mode = 2'b00;
  logic        data_bus_select = 1'b0;

  gpio_input_filter #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .gpio_pins_in(gpio_pins_in), .gpio_pin_state(gpio_pin_state),
    .data_bus_write(data_bus_write), .data_bus_read(data_bus_read), .data_bus_addr(data_bus_addr),
    .data_bus_mode(data_bus_mode), .data_bus_select(data_bus_select));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: pin history since reset, ticks counted while a pin differs, tick phase from edges since last clear.
  logic [15:0] hist[$];
  logic [15:0] m_state, m_en;
  logic [3:0]  m_th;
  logic [7:0]  m_presc;
  int          m_run[16];
  int          n_edges, base;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(16'h0);
    m_state = '0; m_en = '0; m_th = '0; m_presc = '0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    n_edges = 0; base = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [31:0] a);
    case (a)
      32'h4000: return m_state;
      32'h4004: return hist[hist.size()-SS];
      32'h4008: return m_en;
      32'h400C: return {m_presc, 4'h0, m_th};
      default:  return 16'h0;
    endcase
  endfunction

  task automatic model_edge(input logic [15:0] pins, input logic [1:0] mode, input logic sel,
                            input logic [31:0] a, input logic [15:0] wd);
    logic [15:0] sync;
    bit tick, wr, cfgw;
    sync = hist[hist.size()-SS];
`ifdef GPIO_FILTER_PRESCALER_EN
    tick = ((n_edges - base) % (int'(m_presc) + 1)) == int'(m_presc);
`else
    tick = 1'b1;
`endif
    wr   = (mode == 2'b10) && sel;
    cfgw = wr && (a == 32'h400C);
    for (int i = 0; i < 16; i++) begin
      if (!m_en[i]) begin
        m_state[i] = sync[i]; m_run[i] = 0;
      end else if (cfgw || sync[i] == m_state[i]) begin
        m_run[i] = 0;
      end else if (tick) begin
        m_run[i]++;
        if (m_run[i] == int'(m_th) + 1) begin
          m_state[i] = sync[i]; m_run[i] = 0;
        end
      end
    end
    hist.push_back(pins);
    if (hist.size() > 8) void'(hist.pop_front());
    n_edges++;
    if (cfgw) begin
      m_th = wd[3:0];
`ifdef GPIO_FILTER_PRESCALER_EN
      m_presc = wd[15:8];
`endif
      base = n_edges;
    end
    if (wr && a == 32'h4008) m_en = wd;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called once per clock: drive, let the edge happen, advance the model, compare all outputs.
  task automatic step(input logic [15:0] pins, input logic [1:0] mode, input logic sel,
                      input logic [31:0] a, input logic [15:0] wd);
    gpio_pins_in = pins; data_bus_mode = mode; data_bus_select = sel;
    data_bus_addr = a; data_bus_write = wd;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(pins, mode, sel, a, wd);
    #1;
    chk("pin_state", gpio_pin_state, m_state);
    chk("bus_read", data_bus_read, m_read(a));
  endtask

  task automatic idle(input logic [15:0] pins);
    step(pins, 2'b00, 1'b0, 32'h4000, 16'h0);
  endtask

  task automatic wr(input logic [15:0] pins, input logic [31:0] a, input logic [15:0] wd);
    step(pins, 2'b10, 1'b1, a, wd);
  endtask

  task automatic rd_lit(input string name, input logic [15:0] pins, input logic [31:0] a,
                        input logic [15:0] exp);
    step(pins, 2'b01, 1'b1, a, 16'h0);
    chk(name, data_bus_read, exp);
  endtask

  task automatic async_reset(input logic [15:0] pins);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset", gpio_pin_state, 16'h0000);
    idle(pins);
    reset = 1'b0;
  endtask

  logic [15:0] cur;

  initial begin
    model_reset();
    // Reset with all pins high.
    for (int k = 0; k < 4; k++) idle(16'hFFFF);
    chk("reset_state", gpio_pin_state, 16'h0000);
    rd_lit("reset_rd_state", 16'hFFFF, 32'h4000, 16'h0000);
    rd_lit("reset_rd_raw", 16'hFFFF, 32'h4004, 16'h0000);
    rd_lit("reset_rd_en", 16'hFFFF, 32'h4008, 16'h0000);
    rd_lit("reset_rd_cfg", 16'hFFFF, 32'h400C, 16'h0000);
    reset = 1'b0;

    // Passthrough latency.
    for (int k = 0; k < 4; k++) idle(16'h0000);
    for (int k = 1; k <= SS + 1; k++) begin
      idle(16'h00A5);
      chk("passthru", gpio_pin_state, (k == SS + 1) ? 16'h00A5 : 16'h0000);
    end

    // Debounce with threshold 3, prescaler 0.
    for (int k = 0; k < 4; k++) idle(16'h0000);
    wr(16'h0000, 32'h4008, 16'h0001);
    wr(16'h0000, 32'h400C, 16'h0003);
    for (int k = 0; k < 4; k++) idle(16'h0000);
    for (int k = 1; k <= SS + 4; k++) begin
      idle(16'h0001);
      chk("debounce_pin0", {15'h0, gpio_pin_state[0]}, (k == SS + 4) ? 16'h1 : 16'h0);
    end
    for (int k = 0; k < 10; k++) idle(16'h0000);
    chk("debounce_back", {15'h0, gpio_pin_state[0]}, 16'h0);
    for (int k = 0; k < 13; k++) begin
      idle(k < 3 ? 16'h0001 : 16'h0000);
      chk("glitch", {15'h0, gpio_pin_state[0]}, 16'h0);
    end

    // Prescaler field readback, [7:4] always reads 0.
    wr(16'h0000, 32'h400C, 16'hFFF3);
`ifdef GPIO_FILTER_PRESCALER_EN
    rd_lit("cfg_readback", 16'h0000, 32'h400C, 16'hFF03);
    // threshold 1, prescaler 4: accepted on the second tick, 10 edges after the write.
    wr(16'h0001, 32'h400C, 16'h0401);
    for (int k = 2; k <= 11; k++) begin
      idle(16'h0001);
      chk("prescale_pin0", {15'h0, gpio_pin_state[0]}, (k == 11) ? 16'h1 : 16'h0);
    end
`else
    rd_lit("cfg_readback", 16'h0000, 32'h400C, 16'h0003);
`endif

    // Config write mid-count restarts the debounce.
    wr(16'h0000, 32'h400C, 16'h0000);
    for (int k = 0; k < 8; k++) idle(16'h0000);
    wr(16'h0000, 32'h400C, 16'h0005);
    for (int k = 0; k < 3; k++) idle(16'h0000);
    for (int k = 0; k < SS + 4; k++) idle(16'h0001);
    wr(16'h0001, 32'h400C, 16'h0005);
    for (int k = 1; k <= 6; k++) begin
      idle(16'h0001);
      chk("cfg_midcount", {15'h0, gpio_pin_state[0]}, (k == 6) ? 16'h1 : 16'h0);
    end

    // Bus qualification and unmapped reads.
    step(16'h0001, 2'b10, 1'b0, 32'h4008, 16'hFFFF);
    step(16'h0001, 2'b01, 1'b1, 32'h4008, 16'hFFFF);
    step(16'h0001, 2'b11, 1'b1, 32'h4008, 16'hFFFF);
    rd_lit("enable_kept", 16'h0001, 32'h4008, 16'h0001);
    wr(16'h0001, 32'h4010, 16'hFFFF);
    chk("unmapped_rd", data_bus_read, 16'h0000);
    rd_lit("unmapped_4010", 16'h0001, 32'h4010, 16'h0000);

    // Randomized traffic.
    cur = 16'h0001;
    wr(cur, 32'h4008, 16'hF0F3);
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] a;
      cur ^= 16'($urandom & $urandom & $urandom & $urandom);
      r = $urandom_range(0, 39);
      case ($urandom_range(0, 5))
        0: a = 32'h4000;
        1: a = 32'h4004;
        2: a = 32'h4008;
        3: a = 32'h400C;
        4: a = 32'h4010;
        default: a = $urandom;
      endcase
      if (c % 700 == 350) async_reset(cur);
      else if (r == 0) wr(cur, 32'h400C, {6'h0, 2'($urandom), 4'($urandom), 2'h0, 2'($urandom)});
      else if (r == 1) wr(cur, 32'h4008, 16'($urandom));
      else if (r == 2) step(cur, 2'b10, 1'b0, a, 16'($urandom));
      else if (r == 3) step(cur, 2'($urandom), 1'b1, a, 16'($urandom));
      else step(cur, 2'b01, 1'($urandom), a, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_input_filter.md
GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per pin (legal 2..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port gpio_pins_in  input  16  raw asynchronous GPIO pin levels.
REQ-005 SHALL have port gpio_pin_state  output  16  filtered pin levels, feeds the extended interrupt controller's pin input.
REQ-006 SHALL have port data_bus_write  input  16  bus write data.
REQ-007 SHALL have port data_bus_read  output  16  bus read data, combinational from data_bus_addr.
REQ-008 SHALL have port data_bus_addr  input  32  bus byte address.
REQ-009 SHALL have port data_bus_mode  input  2  00 idle, 01 read, 10 write, 11 ignored.
REQ-010 SHALL have port data_bus_select  input  1  slave select.

Function
REQ-011 SHALL decode registers: 0x4000 filtered state (RO), 0x4004 synchronized raw state (RO), 0x4008 filter_enable (RW), 0x400C config (RW: [3:0] threshold, [15:8] prescaler, [7:4] read 0).
REQ-012 SHALL perform a write only when data_bus_mode==10 and data_bus_select==1; writes to RO or unmapped addresses are ignored.
REQ-013 SHALL return 0 on data_bus_read for unmapped addresses, independent of mode/select.
REQ-014 SHALL pass each pin through SYNC_STAGES flops; sync_raw is the last stage.
REQ-015 SHALL generate tick from a prescale counter counting 0..prescaler; tick asserted in the cycle counter==prescaler, counter then returns to 0; prescaler 0 gives tick every cycle.
REQ-016 SHALL, for a pin with filter_enable=0, load gpio_pin_state[i] with sync_raw[i] every cycle and hold its debounce counter at 0.
REQ-017 SHALL, for an enabled pin whose sync_raw equals gpio_pin_state, clear its 4-bit debounce counter that cycle (tick or not).
REQ-018 SHALL, for an enabled pin whose sync_raw differs, on tick: if counter==threshold, load gpio_pin_state[i] from sync_raw[i] and clear counter; else increment counter.
REQ-019 SHALL therefore accept a stable change after exactly threshold+1 ticks; threshold 0 accepts on the first tick.
REQ-020 SHALL, on any write to 0x400C, clear the prescale counter and all debounce counters in the same cycle; gpio_pin_state unchanged.
REQ-021 SHALL, on write to 0x4008, apply the new enable mask from the next cycle; newly enabled pins start with counter 0; newly disabled pins follow REQ-016.
REQ-022 SHALL never saturate or wrap a debounce counter past threshold (counter <= 15 by construction).

Reset
REQ-023 SHALL on reset clear synchronizer flops, gpio_pin_state, filter_enable, config, prescale counter and all debounce counters to 0.
REQ-024 SHALL take effect immediately on reset assertion, mid-operation included, and resume filtering from the first clk edge after deassertion.

Configuration
REQ-025 SHALL use macro GPIO_FILTER_PRESCALER_EN: defined -> prescaler field and counter as in REQ-015; undefined -> no prescale counter, tick is constant 1, config[15:8] reads 0 and writes to it are ignored.

Verification
REQ-026 Reset: assert reset with gpio_pins_in=0xFFFF -> gpio_pin_state=0x0000, all registers read 0.
REQ-027 Passthrough: enable=0x0000, gpio_pins_in 0x0000->0x00A5 -> gpio_pin_state=0x00A5 exactly SYNC_STAGES+1 cycles later.
REQ-028 Debounce: enable=0x0001, threshold=3, prescaler=0, pin0 0->1 held -> gpio_pin_state[0]=1 after SYNC_STAGES+4 cycles; 3-cycle glitch -> no change.
REQ-029 Prescale (macro defined): threshold=1, prescaler=4, pin0 held high -> accepted after exactly 2 ticks (10 cycles post-sync); macro undefined -> prescaler write reads back 0.
REQ-030 Config write mid-count: threshold=5, pin held changed for 4 ticks, write 0x400C -> counters cleared, acceptance needs full 6 further ticks.
REQ-031 Bus: write with data_bus_select=0 or mode=01 -> no register change; read of 0x4010 -> 0x0000.
